// File: rtl/sand_pkg.sv
// Shared types for the falling-sand step controller.
// Exports: state_t FSM encoding, CELL_EMPTY / CELL_SAND cell values.
package sand_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_SELF,
    CHK_SELF,
    CHK_DOWN,
    CHK_D1,
    CHK_D2,
    WR_DST,
    WR_SRC,
    NEXT,
    DONE
  } state_t;

  localparam logic CELL_EMPTY = 1'b0;
  localparam logic CELL_SAND  = 1'b1;

endpackage

// File: rtl/sand_scan_addr_gen.sv
// Bottom-up raster cell address, column counter, edge/last flags and neighbours.
// Ports: clk_i, reset_i, start_i, advance_i -> addr/next/below/diag addrs, edge and last flags.
module sand_scan_addr_gen
  import sand_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [ADDR_WIDTH-1:0] below_o,
  output logic [ADDR_WIDTH-1:0] below_left_o,
  output logic [ADDR_WIDTH-1:0] below_right_o,
  output logic                  at_left_o,
  output logic                  at_right_o,
  output logic                  last_o
);

  localparam int XW = (ACTIVE_COLUMNS > 1) ? $clog2(ACTIVE_COLUMNS) : 1;

  localparam logic [ADDR_WIDTH-1:0] START_ADDR =
    ADDR_WIDTH'((ACTIVE_ROWS - 2) * ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] ROW_BACK =
    ADDR_WIDTH'(2 * ACTIVE_COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS =
    ADDR_WIDTH'(ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(ACTIVE_COLUMNS - 1);
  localparam logic [XW-1:0] X_MAX = XW'(ACTIVE_COLUMNS - 1);

  logic [XW-1:0]         x_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  assign at_left_o     = (x_q == '0);
  assign at_right_o    = (x_q == X_MAX);
  assign last_o        = (addr_q == LAST_ADDR);
  assign addr_o        = addr_q;
  // end of a row jumps up one row and back to column 0
  assign next_addr_o   = at_right_o ? (addr_q - ROW_BACK)
                                    : (addr_q + ADDR_WIDTH'(1));
  assign below_o       = addr_q + COLS;
  assign below_left_o  = below_o - ADDR_WIDTH'(1);
  assign below_right_o = below_o + ADDR_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q    <= '0;
      addr_q <= '0;
    end else if (start_i) begin
      x_q    <= '0;
      addr_q <= START_ADDR;
    end else if (advance_i) begin
      x_q    <= at_right_o ? '0 : x_q + XW'(1);
      addr_q <= next_addr_o;
    end
  end

endmodule

// File: rtl/sand_step_controller.sv
// One falling-sand step per frame over the 1-bit game RAM, plus spawn writes.
// Ports: frame/spawn inputs, RAM read port, shared write port, busy/done/overrun.
module sand_step_controller
  import sand_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = 19
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  frame_start_i,
  input  logic                  spawn_req_i,
  input  logic [ADDR_WIDTH-1:0] spawn_addr_i,
  output logic                  spawn_ack_o,
  output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
  input  logic                  ram_read_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  wr_data_o,
  output logic                  busy_o,
  output logic                  step_done_o,
  output logic                  step_overrun_o
);

  state_t state_q;
  logic   dir_q;
  logic   ack_q;
  logic   wr_en_q;
  logic   wr_data_q;
  logic   busy_q;
  logic   done_q;
  logic   ovr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] below;
  logic [ADDR_WIDTH-1:0] below_l;
  logic [ADDR_WIDTH-1:0] below_r;
  logic                  at_left;
  logic                  at_right;
  logic                  last;

  logic                  between;
  logic                  empty;
  logic                  start;
  logic                  advance;
  logic                  pref_ok;
  logic                  other_ok;
  logic [ADDR_WIDTH-1:0] pref_addr;
  logic [ADDR_WIDTH-1:0] other_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign between  = (state_q == IDLE) || (state_q == DONE);
  assign empty    = (ram_read_data_i == CELL_EMPTY);
  assign start    = between && frame_start_i;
  assign advance  = ((state_q == CHK_SELF) && empty && !last)
                 || ((state_q == NEXT) && !last);

  // diagonal off the grid edge counts as occupied and is never read
  assign pref_addr  = dir_q ? below_r : below_l;
  assign other_addr = dir_q ? below_l : below_r;
  assign pref_ok    = dir_q ? !at_right : !at_left;
  assign other_ok   = dir_q ? !at_left  : !at_right;

  sand_scan_addr_gen #(
    .ACTIVE_COLUMNS (ACTIVE_COLUMNS),
    .ACTIVE_ROWS    (ACTIVE_ROWS),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_addr (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start),
    .advance_i     (advance),
    .addr_o        (addr),
    .next_addr_o   (next_addr),
    .below_o       (below),
    .below_left_o  (below_l),
    .below_right_o (below_r),
    .at_left_o     (at_left),
    .at_right_o    (at_right),
    .last_o        (last)
  );

  // read address is combinational so data lands in the following state
  always_comb begin
    rd_addr = '0;
    case (state_q)
      RD_SELF:  rd_addr = addr;
      CHK_SELF: rd_addr = !empty ? below
                        : (last ? addr : next_addr);
      CHK_DOWN: rd_addr = pref_ok ? pref_addr : other_addr;
      CHK_D1:   rd_addr = other_addr;
      default:  rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      ack_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= frame_start_i && busy_q;
      case (state_q)
        IDLE, DONE: begin
          if (frame_start_i) begin
            state_q <= RD_SELF;
            busy_q  <= 1'b1;
            dir_q   <= ~dir_q;
          end else begin
            state_q <= IDLE;
            // ack_q high means the requester has not yet dropped the request
            if (spawn_req_i && !ack_q) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= spawn_addr_i;
              wr_data_q <= CELL_SAND;
              ack_q     <= 1'b1;
            end
          end
        end
        RD_SELF: state_q <= CHK_SELF;
        CHK_SELF: begin
          if (!empty) begin
            state_q <= CHK_DOWN;
          end else if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        CHK_DOWN: begin
          if (empty) begin
            state_q   <= WR_DST;
            wr_en_q   <= 1'b1;
            wr_addr_q <= below;
            wr_data_q <= CELL_SAND;
          end else if (pref_ok) begin
            state_q <= CHK_D1;
          end else if (other_ok) begin
            state_q <= CHK_D2;
          end else begin
            state_q <= NEXT;
          end
        end
        CHK_D1: begin
          if (empty) begin
            state_q   <= WR_DST;
            wr_en_q   <= 1'b1;
            wr_addr_q <= pref_addr;
            wr_data_q <= CELL_SAND;
          end else if (other_ok) begin
            state_q <= CHK_D2;
          end else begin
            state_q <= NEXT;
          end
        end
        CHK_D2: begin
          if (empty) begin
            state_q   <= WR_DST;
            wr_en_q   <= 1'b1;
            wr_addr_q <= other_addr;
            wr_data_q <= CELL_SAND;
          end else begin
            state_q <= NEXT;
          end
        end
        WR_DST: begin
          state_q   <= WR_SRC;
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr;
          wr_data_q <= CELL_EMPTY;
        end
        WR_SRC: state_q <= NEXT;
        NEXT: begin
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD_SELF;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_read_addr_o = rd_addr;
  assign spawn_ack_o     = ack_q;
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign busy_o          = busy_q;
  assign step_done_o     = done_q;
  assign step_overrun_o  = ovr_q;

endmodule

// File: tb/tb_sand_step_controller.sv
// Scoreboard bench for sand_step_controller on a 4x3 grid.
// Behavioural 12-cell RAM with 1-cycle read latency.
module tb_sand_step_controller;

  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fs = 1'b0;
  logic          spawn_req = 1'b0;
  logic [AW-1:0] spawn_addr = '0;
  logic          spawn_ack;
  logic [AW-1:0] rd_addr;
  logic          rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          busy;
  logic          done;
  logic          ovr;

  logic [11:0]   mem = '0;
  logic [11:0]   img = '0;
  logic          load = 1'b0;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  busy_cnt, done_cnt, ovr_cnt, ack_cnt, done_cyc, ack_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) mem <= img;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  sand_step_controller #(
    .ACTIVE_COLUMNS (4),
    .ACTIVE_ROWS    (3),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .frame_start_i   (fs),
    .spawn_req_i     (spawn_req),
    .spawn_addr_i    (spawn_addr),
    .spawn_ack_o     (spawn_ack),
    .ram_read_addr_o (rd_addr),
    .ram_read_data_i (rd_data),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .wr_data_o       (wr_data),
    .busy_o          (busy),
    .step_done_o     (done),
    .step_overrun_o  (ovr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.a = AW'(a);
    e.d = d[0];
    exp_q.push_back(e);
  endtask

  task automatic clear_cnt();
    busy_cnt = 0;
    done_cnt = 0;
    ovr_cnt  = 0;
    ack_cnt  = 0;
    done_cyc = -1;
    ack_cyc  = -1;
  endtask

  task automatic load_ram(input logic [11:0] v);
    @(posedge clk); #1;
    img = v;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spawn_ack) break;
    end
    @(posedge clk); #1;
    spawn_req = 1'b0;
  endtask

  task automatic run_step(input string name, input logic [11:0] init,
                          input logic [11:0] fin, input int busy_exp,
                          input bit mid_fs, input bit spawn);
    load_ram(init);
    clear_cnt();
    pulse_fs();
    repeat (3) @(posedge clk);
    #1;
    if (mid_fs) pulse_fs();
    if (spawn) begin
      spawn_addr = 4'd7;
      spawn_req  = 1'b1;
    end
    wait_done(name);
    if (spawn) wait_ack();
    repeat (2) @(negedge clk);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_busy_cycles"}, busy_cnt, busy_exp);
    chk({name, "_overrun_cnt"}, ovr_cnt, mid_fs ? 1 : 0);
    chk({name, "_ram"}, int'(mem), int'(fin));
    chk({name, "_writes_left"}, exp_q.size(), 0);
    chk({name, "_ack_cnt"}, ack_cnt, spawn ? 1 : 0);
    if (spawn) chk({name, "_ack_cycle"}, ack_cyc, done_cyc + 1);
  endtask

  function automatic int outs();
    return int'({spawn_ack, rd_addr, wr_en, wr_addr, wr_data, busy, done, ovr});
  endfunction

  initial begin
    int t0;
    clear_cnt();
    fork
      forever @(posedge clk) cyc++;
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL wr_seq: unexpected write addr %0d data %0d",
                       wr_addr, wr_data);
            end else begin
              wr_t e;
              e = exp_q.pop_front();
              if (wr_addr != e.a || wr_data != e.d) begin
                errors++;
                $display("FAIL wr_seq: got (%0d,%0d) expected (%0d,%0d)",
                         wr_addr, wr_data, e.a, e.d);
              end
            end
          end
          if (busy) begin
            busy_cnt++;
            checks++;
            if (rd_addr >= 12) begin
              errors++;
              $display("FAIL rd_range: got %0d expected < 12", rd_addr);
            end
          end
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
          end
          if (ovr) ovr_cnt++;
          if (spawn_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            checks++;
            if (busy) begin
              errors++;
              $display("FAIL ack_busy: got busy 1 expected 0");
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // dir=1: single grain falls straight down
    push(5, 1); push(1, 0);
    run_step("t1_single", 12'h002, 12'h020, 14, 1'b0, 1'b0);

    // dir=0: left diagonal skipped at x=0, grain 0 goes right to 5
    push(5, 1); push(0, 0);
    run_step("t3_edge", 12'h311, 12'h330, 19, 1'b0, 1'b0);

    // stack: each grain moves once, top grain drops into vacated 5
    push(8, 1); push(4, 0); push(9, 1); push(5, 0);
    push(10, 1); push(6, 0); push(5, 1); push(1, 0);
    run_step("t2_stack", 12'h072, 12'h720, 29, 1'b0, 1'b0);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // after reset the first step prefers right, the next prefers left
    push(10, 1); push(5, 0);
    run_step("t4_right", 12'h220, 12'h600, 15, 1'b0, 1'b0);
    push(8, 1); push(5, 0);
    run_step("t4_left", 12'h220, 12'h300, 15, 1'b0, 1'b0);

    // spawn held during a step is served right after DONE
    push(5, 1); push(1, 0); push(7, 1);
    run_step("t5_spawn", 12'h002, 12'h0A0, 14, 1'b0, 1'b1);

    // frame_start while busy is dropped with an overrun pulse
    push(5, 1); push(1, 0);
    run_step("t6_overrun", 12'h002, 12'h020, 14, 1'b1, 1'b0);

    // reset mid-step, then an immediate spawn proves the FSM is idle
    load_ram(12'h002);
    clear_cnt();
    pulse_fs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", outs(), 0);
    @(posedge clk); #1;
    clear_cnt();
    push(11, 1);
    t0 = cyc;
    spawn_addr = 4'd11;
    spawn_req  = 1'b1;
    wait_ack();
    repeat (2) @(negedge clk);
    chk("t6_reset_ack_cnt", ack_cnt, 1);
    chk("t6_reset_ack_cycle", ack_cyc, t0 + 1);
    chk("t6_reset_ram", int'(mem), 12'h802);
    chk("t6_reset_writes_left", exp_q.size(), 0);
    chk("t6_reset_busy", busy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sand_step_controller.md
Name: sand_step_controller

Overview:
- Sequences one falling-sand physics step per video frame over the 1-bit game RAM (1 = sand, 0 = empty).
- Scans cells bottom-up and moves each grain down, down-left or down-right.
- Mirrors every write to the VRAM write port so the display reflects the new state.
- Also arbitrates the shared write path with a user spawn requester; spawns are served only between steps.

Parameters:
- ACTIVE_COLUMNS, 640: grid width in cells.
- ACTIVE_ROWS, 480: grid height in cells.
- ADDR_WIDTH, 19: RAM address width; must satisfy 2^ADDR_WIDTH >= ACTIVE_COLUMNS*ACTIVE_ROWS.

Ports:
- clk_i  in  1  system/pixel clock.
- reset_i  in  1  synchronous, active-high reset.
- frame_start_i  in  1  one-cycle pulse at start of vertical blank.
- spawn_req_i  in  1  spawn request; held high until acknowledged.
- spawn_addr_i  in  ADDR_WIDTH  cell to set to sand; stable while spawn_req_i is high.
- spawn_ack_o  out  1  one-cycle pulse in the cycle the spawn write is issued.
- ram_read_addr_o  out  ADDR_WIDTH  game RAM read address.
- ram_read_data_i  in  1  game RAM read data, valid exactly 1 cycle after its address.
- wr_en_o  out  1  write strobe, shared by game RAM and VRAM.
- wr_addr_o  out  ADDR_WIDTH  write address, shared by both RAMs.
- wr_data_o  out  1  write data, shared by both RAMs.
- busy_o  out  1  high while a step is in progress.
- step_done_o  out  1  one-cycle pulse when a step completes.
- step_overrun_o  out  1  one-cycle pulse when frame_start_i arrives while busy.

Behaviour:
- Reset: state IDLE; all outputs 0; direction toggle dir = 0 (prefer left). Reset mid-step abandons the step immediately; already-written cells stay as written.
- Scan order: rows ACTIVE_ROWS-2 down to 0. The bottom row is never a source. Columns run 0 to ACTIVE_COLUMNS-1 within a row.
- Addressing: addr = y*ACTIVE_COLUMNS + x. Use no multiplier; the cell address is a register that is incremented or stepped back by 2*ACTIVE_COLUMNS-1 at a row change.
  - below = addr+ACTIVE_COLUMNS
  - below-left = below-1
  - below-right = below+1
- States:
  - IDLE. frame_start_i -> RD_SELF with addr = (ACTIVE_ROWS-2)*ACTIVE_COLUMNS, busy_o = 1, dir flipped. Otherwise, if spawn_req_i: wr_en_o = 1, wr_addr_o = spawn_addr_i, wr_data_o = 1, spawn_ack_o = 1, stay in IDLE. frame_start_i wins over a simultaneous spawn; the spawn waits.
  - RD_SELF. Drive the read address for the current cell -> CHK_SELF.
  - CHK_SELF. If data = 0: advance the cell and drive its read address in the same cycle (1 cycle per empty cell); the last cell goes to DONE. If data = 1: drive the below address -> CHK_DOWN.
  - CHK_DOWN. If 0: dst = below -> WR_DST. Else read the preferred diagonal -> CHK_D1.
  - CHK_D1. If 0: dst = that diagonal -> WR_DST. Else read the other diagonal -> CHK_D2.
  - CHK_D2. If 0: dst = that diagonal -> WR_DST. Else -> NEXT.
  - Preferred diagonal: left when dir = 0, right when dir = 1.
  - Edges: at x = 0 the left diagonal is treated as occupied without a read; at x = ACTIVE_COLUMNS-1 the same applies to the right diagonal. The FSM skips that CHK state.
  - WR_DST: write 1 to dst -> WR_SRC.
  - WR_SRC: write 0 to the current cell -> NEXT.
  - NEXT: advance the cell -> RD_SELF, or -> DONE after the last cell.
  - DONE: step_done_o = 1, busy_o = 0 -> IDLE.
- Each grain moves at most once per step; bottom-up order guarantees this.
- Writes: at most one per cycle. wr_en_o is never asserted in a cycle without a valid address/data.
- While busy: spawn_req_i is not acked. frame_start_i is dropped and pulses step_overrun_o; the step continues unaffected.
- Cost: 1 cycle per empty cell, at most 8 cycles per grain.

Decomposition:
- sand_pkg:
  - state enum: IDLE, RD_SELF, CHK_SELF, CHK_DOWN, CHK_D1, CHK_D2, WR_DST, WR_SRC, NEXT, DONE.
  - cell-value constants CELL_EMPTY = 0, CELL_SAND = 1.
- Sub-module sand_scan_addr_gen: holds x and the cell address. Provides the advance operation, the last-cell flag, the edge flags (x = 0, x = ACTIVE_COLUMNS-1), and the below/below-left/below-right addresses.

Test Plan (bench uses ACTIVE_COLUMNS = 4, ACTIVE_ROWS = 3 and a behavioural 12-cell RAM with 1-cycle read latency):
1. Sand at addr 1 only; frame_start_i pulse -> writes (5,1) then (1,0). Final RAM has only addr 5 set. step_done_o pulses once; busy_o is high throughout the step.
2. Sand at 1, 5, 4, 6 (stack with both diagonals blocked at row 1): step -> grain 5 moves to 9. Next, grain 1 moves to 5 (now empty); it never skips two rows.
3. Sand at 0 and 4, dir = 0: left diagonal is skipped at the x = 0 edge. Grain 0 goes to the empty right diagonal 5, with no read of an out-of-row address.
4. Sand at 5 and 9, both diagonals 8 and 10 empty: the first step (dir flips to 1) moves 5 to 10; the second step's preference alternates to left.
5. spawn_req_i with addr 7 held during a step -> no ack until DONE. Ack arrives in the first IDLE cycle, with a write of (7,1).
6. Second frame_start_i mid-step -> step_overrun_o pulses once and the result equals the single-step result. reset_i mid-step -> all outputs 0 next cycle and state IDLE.
